// File: rtl/nibbler_pkg.sv
// Shared types and ALU control codes for the nibbler control sequencer.
// The 6-bit ALU codes are packed as {carryIn, mode, func[3:0]}.
package nibbler_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LIT  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUBI = 4'h3,
        OP_NORI = 4'h4,
        OP_CMPI = 4'h5,
        OP_OUT  = 4'h6,
        OP_JZ   = 4'h8,
        OP_JNZ  = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    localparam logic [5:0] ALU_PASS_A = 6'b1_0_0000;
    localparam logic [5:0] ALU_PASS_B = 6'b0_1_1010;
    localparam logic [5:0] ALU_ADD    = 6'b1_0_1001;
    localparam logic [5:0] ALU_SUB    = 6'b0_0_0110;
    localparam logic [5:0] ALU_NOR    = 6'b0_1_0001;

    // Opcodes whose ALU result is written back to the accumulator.
    function automatic logic writes_acc(input opcode_e op);
        return (op == OP_LIT) || (op == OP_ADDI) ||
               (op == OP_SUBI) || (op == OP_NORI);
    endfunction

    // Opcodes whose ALU result refreshes the zero flag (CMPI compares only).
    function automatic logic updates_flag(input opcode_e op);
        return writes_acc(op) || (op == OP_CMPI);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction-fetch handshake plus the ALU/datapath control bus of the sequencer.
// The master side is the sequencer; the slave side is the instruction source and datapath.
interface control_sequencer_if;
    logic       instrValid;
    logic [7:0] instr;
    logic       instrReady;
    logic [7:0] pc;
    logic       carryIn;
    logic       mode;
    logic [3:0] func;
    logic [3:0] immOut;
    logic [3:0] aluOut;
    logic       accLoad;
    logic       outStrobe;
    logic       zeroFlag;
    logic       halted;

    modport master (
        input  instrValid, instr, aluOut,
        output instrReady, pc, carryIn, mode, func, immOut,
               accLoad, outStrobe, zeroFlag, halted
    );

    modport slave (
        output instrValid, instr, aluOut,
        input  instrReady, pc, carryIn, mode, func, immOut,
               accLoad, outStrobe, zeroFlag, halted
    );
endinterface

// File: rtl/alu_code_decoder.sv
// Combinational opcode-to-ALU-control table; unknown opcodes fall back to pass A.
module alu_code_decoder
    import nibbler_pkg::*;
(
    input  opcode_e    opcode,
    output logic [5:0] alu_code
);

    // Map each opcode onto its {carryIn, mode, func} control word.
    always_comb begin
        alu_code = ALU_PASS_A;
        case (opcode)
            OP_LIT:  alu_code = ALU_PASS_B;
            OP_ADDI: alu_code = ALU_ADD;
            OP_SUBI: alu_code = ALU_SUB;
            OP_NORI: alu_code = ALU_NOR;
            OP_CMPI: alu_code = ALU_SUB;
            default: alu_code = ALU_PASS_A;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Nibbler control sequencer: FETCH/DECODE/EXEC/HALT FSM driving a 4-bit ALU datapath.
// Optional feature macro NIBBLER_BRANCH_EN enables the JZ/JNZ conditional branches;
// without it those opcodes execute as NOPs and no branch logic is built.
// All outputs come straight from flops, computed one cycle ahead from the next state.
module control_sequencer
    import nibbler_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    control_sequencer_if.master bus
);

    state_e     state_q, state_d;
    opcode_e    opcode_q, opcode_d;
    logic [3:0] imm_q, imm_d;
    logic [7:0] pc_q, pc_d;
    logic       zero_flag_q, zero_flag_d;
    logic [5:0] alu_ctrl_q, alu_ctrl_d;
    logic       acc_load_q, acc_load_d;
    logic       out_strobe_q, out_strobe_d;
    logic       instr_ready_q, instr_ready_d;
    logic       halted_q, halted_d;
    logic       handshake;
    logic [5:0] dec_code;

    // The decoder looks at the next opcode so the control word is ready in DECODE.
    alu_code_decoder u_decoder (
        .opcode   (opcode_d),
        .alu_code (dec_code)
    );

    // Next-state, program counter, flag and registered-output computation.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        imm_d         = imm_q;
        pc_d          = pc_q;
        zero_flag_d   = zero_flag_q;
        handshake     = instr_ready_q && bus.instrValid;

        case (state_q)
            ST_FETCH: begin
                if (handshake) begin
                    state_d  = ST_DECODE;
                    opcode_d = opcode_e'(bus.instr[7:4]);
                    imm_d    = bus.instr[3:0];
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = (opcode_q == OP_HALT) ? ST_HALT : ST_FETCH;
                if (updates_flag(opcode_q)) begin
                    zero_flag_d = (bus.aluOut == 4'h0);
                end
                pc_d = pc_q + 8'd1;
`ifdef NIBBLER_BRANCH_EN
                if (((opcode_q == OP_JZ) && zero_flag_q) ||
                    ((opcode_q == OP_JNZ) && !zero_flag_q)) begin
                    pc_d = {imm_q, 4'h0};
                end
`endif
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        instr_ready_d = (state_d == ST_FETCH);
        halted_d      = (state_d == ST_HALT);
        alu_ctrl_d    = ((state_d == ST_DECODE) || (state_d == ST_EXEC)) ? dec_code : ALU_PASS_A;
        acc_load_d    = (state_d == ST_EXEC) && writes_acc(opcode_d);
        out_strobe_d  = (state_d == ST_EXEC) && (opcode_d == OP_OUT);
    end

    // State and output registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            opcode_q      <= OP_NOP;
            imm_q         <= 4'h0;
            pc_q          <= 8'h00;
            zero_flag_q   <= 1'b0;
            alu_ctrl_q    <= ALU_PASS_A;
            acc_load_q    <= 1'b0;
            out_strobe_q  <= 1'b0;
            instr_ready_q <= 1'b1;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            imm_q         <= imm_d;
            pc_q          <= pc_d;
            zero_flag_q   <= zero_flag_d;
            alu_ctrl_q    <= alu_ctrl_d;
            acc_load_q    <= acc_load_d;
            out_strobe_q  <= out_strobe_d;
            instr_ready_q <= instr_ready_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.instrReady                    = instr_ready_q;
    assign bus.pc                            = pc_q;
    assign {bus.carryIn, bus.mode, bus.func} = alu_ctrl_q;
    assign bus.immOut                        = imm_q;
    assign bus.accLoad                       = acc_load_q;
    assign bus.outStrobe                     = out_strobe_q;
    assign bus.zeroFlag                      = zero_flag_q;
    assign bus.halted                        = halted_q;

endmodule
